// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU.
// Imported by alu_core and alu_pipe.
package alu_pkg;

    localparam int unsigned OP_BITS = 6;

    typedef enum logic [OP_BITS-1:0] {
        OP_SRL = 6'b000010,
        OP_SRA = 6'b000011,
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_NOR = 6'b100111
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic illegal;
    } alu_flags_t;

    function automatic logic op_is_legal(input logic [OP_BITS-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_SRL, OP_SRA, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR, OP_NOR: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes the opcode, computes the result and status flags.
// Unknown opcodes yield a zero result with only the illegal and zero flags set.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS  = 8,
    parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
    input  logic [N_BITS-1:0]  i_d0,
    input  logic [N_BITS-1:0]  i_d1,
    input  logic [OP_BITS-1:0] i_opcode,
    output logic [N_BITS-1:0]  o_result,
    output alu_flags_t         o_flags
);

    logic [N_BITS:0]    w_wide;
    logic [SH_BITS-1:0] w_sh;
    logic               w_sign_a;
    logic               w_sign_b;

    // Upper operand-B bits are ignored for shifts.
    assign w_sh     = i_d1[SH_BITS-1:0];
    assign w_sign_a = i_d0[N_BITS-1];
    assign w_sign_b = i_d1[N_BITS-1];

    always_comb begin
        w_wide   = '0;
        o_result = '0;
        o_flags  = '0;
        case (i_opcode)
            OP_ADD: begin
                w_wide        = {1'b0, i_d0} + {1'b0, i_d1};
                o_result      = w_wide[N_BITS-1:0];
                o_flags.carry = w_wide[N_BITS];
                o_flags.ovf   = (w_sign_a == w_sign_b) && (o_result[N_BITS-1] != w_sign_a);
            end
            OP_SUB: begin
                // Bit N of the widened difference is the borrow (d0 < d1 unsigned).
                w_wide        = {1'b0, i_d0} - {1'b0, i_d1};
                o_result      = w_wide[N_BITS-1:0];
                o_flags.carry = w_wide[N_BITS];
                o_flags.ovf   = (w_sign_a != w_sign_b) && (o_result[N_BITS-1] != w_sign_a);
            end
            OP_AND: o_result = i_d0 & i_d1;
            OP_OR:  o_result = i_d0 | i_d1;
            OP_XOR: o_result = i_d0 ^ i_d1;
            OP_NOR: o_result = ~(i_d0 | i_d1);
            OP_SRL: o_result = i_d0 >> w_sh;
            OP_SRA: o_result = N_BITS'($signed(i_d0) >>> w_sh);
            default: begin
                o_result        = '0;
                o_flags.illegal = 1'b1;
            end
        endcase
        o_flags.zero = (o_result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshakes; S1 holds operands, S2 holds result/flags.
// in_ready depends combinationally on out_ready (no skid buffer).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS  = 8,
    parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_BITS-1:0]  d0,
    input  logic [N_BITS-1:0]  d1,
    input  logic [OP_BITS-1:0] opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BITS-1:0]  out,
    output logic               zero,
    output logic               carry,
    output logic               ovf,
    output logic               illegal
);

    logic               r_s1_valid;
    logic [N_BITS-1:0]  r_d0;
    logic [N_BITS-1:0]  r_d1;
    logic [OP_BITS-1:0] r_op;

    logic               r_out_valid;
    logic [N_BITS-1:0]  r_out;
    alu_flags_t         r_flags;

    logic [N_BITS-1:0]  w_result;
    alu_flags_t         w_flags;
    logic               w_adv1;
    logic               w_adv2;

    assign w_adv2   = r_s1_valid && (!r_out_valid || out_ready);
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    alu_core #(
        .N_BITS  (N_BITS),
        .SH_BITS (SH_BITS)
    ) u_core (
        .i_d0     (r_d0),
        .i_d1     (r_d1),
        .i_opcode (r_op),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_d0        <= '0;
            r_d1        <= '0;
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_flags     <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            if (w_adv1 && in_valid) begin
                r_d0 <= d0;
                r_d1 <= d1;
                r_op <= opcode;
            end
            // A take with a waiting S1 op refills S2 in the same cycle, so no bubble.
            if (w_adv2) begin
                r_out_valid <= 1'b1;
                r_out       <= w_result;
                r_flags     <= w_flags;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zero      = r_flags.zero;
    assign carry     = r_flags.carry;
    assign ovf       = r_flags.ovf;
    assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (N_BITS=8): directed scenarios plus randomized traffic
// scored against an arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic [5:0] opcode = 6'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       zero, carry, ovf, illegal;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] q[$];
    logic [5:0]  legal_ops[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000010, 6'b000011};

    alu_pipe #(.N_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Expected {out, zero, carry, ovf, illegal} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [5:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int ua, ub, sa, sb, r, amt;
        logic c, v, il;
        logic [7:0] res;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        amt = ub % 8;
        c = 1'b0; v = 1'b0; il = 1'b0; r = 0;
        case (op)
            6'b100000: begin
                r = ua + ub; c = (r > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            6'b100010: begin
                r = ua - ub; c = (ua < ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            6'b100100: r = ua & ub;
            6'b100101: r = ua | ub;
            6'b100110: r = ua ^ ub;
            6'b100111: r = ~(ua | ub);
            6'b000010: r = ua / (1 << amt);
            6'b000011: r = sa >>> amt;
            default:   il = 1'b1;
        endcase
        res = r[7:0];
        return {res, (res == 8'h00), c, v, il};
    endfunction

    function automatic logic [11:0] obs();
        return {out, zero, carry, ovf, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, score the output take and the input accept, advance.
    task automatic step(input logic iv, input logic [5:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy, output logic acc);
        logic [11:0] e;
        in_valid = iv; opcode = op; d0 = a; d1 = b; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check($sformatf("result_op%b", e[0] ? 6'b111111 : 6'b000000), 32'(obs()),
                      32'(e));
            end
        end
        if (acc) q.push_back(model(op, a, b));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
    endtask

    // Wait (bounded) for out_valid, then compare against a literal expectation.
    task automatic expect_next(input string tag, input logic [11:0] exp);
        logic acc;
        for (int i = 0; i < 5 && !out_valid; i++) step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(obs()), 32'(exp));
    endtask

    initial begin
        logic acc;
        logic [11:0] held;
        logic [5:0] op;

        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // ADD overflow and two-edge latency
        step(1'b1, 6'b100000, 8'h7F, 8'h01, 1'b1, acc);
        check("t1_accept", 32'(acc), 32'd1);
        check("t1_not_yet", 32'(out_valid), 32'd0);
        step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        check("t1_latency", 32'(out_valid), 32'd1);
        check("t1_add_ovf", 32'(obs()), 32'({8'h80, 1'b0, 1'b0, 1'b1, 1'b0}));
        idle(2);
        check("t1_drained", 32'(out_valid), 32'd0);

        // SUB borrow and zero
        step(1'b1, 6'b100010, 8'h00, 8'h01, 1'b1, acc);
        step(1'b1, 6'b100010, 8'h05, 8'h05, 1'b1, acc);
        expect_next("t2_sub_borrow", {8'hFF, 1'b0, 1'b1, 1'b0, 1'b0});
        step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        expect_next("t2_sub_zero", {8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        idle(2);

        // Shifts, with upper shift-amount bits ignored
        step(1'b1, 6'b000011, 8'h80, 8'h03, 1'b1, acc);
        step(1'b1, 6'b000010, 8'h80, 8'h0B, 1'b1, acc);
        expect_next("t3_sra", {8'hF0, 1'b0, 1'b0, 1'b0, 1'b0});
        step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        expect_next("t3_srl", {8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
        idle(2);

        // Illegal opcode flows through, next legal op clears the flag
        step(1'b1, 6'b111111, 8'hAA, 8'h00, 1'b1, acc);
        step(1'b1, 6'b100000, 8'h01, 8'h02, 1'b1, acc);
        expect_next("t4_illegal", {8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
        step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        expect_next("t4_legal_after", {8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
        idle(3);
        check("t4_drained", 32'(out_valid), 32'd0);

        // Stall: two ops buffered, third refused, output held, then ordered drain
        step(1'b1, 6'b100000, 8'h10, 8'h20, 1'b0, acc);
        check("t5_acc_a", 32'(acc), 32'd1);
        step(1'b1, 6'b100000, 8'h30, 8'h40, 1'b0, acc);
        check("t5_acc_b", 32'(acc), 32'd1);
        held = obs();
        check("t5_first_out", 32'(held), 32'({8'h30, 1'b0, 1'b0, 1'b0, 1'b0}));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 6'b100000, 8'h50, 8'h60, 1'b0, acc);
            check("t5_refused", 32'(acc), 32'd0);
            check("t5_in_ready_low", 32'(in_ready), 32'd0);
            check("t5_out_stable", 32'(obs()), 32'(held));
            check("t5_valid_held", 32'(out_valid), 32'd1);
        end
        step(1'b1, 6'b100000, 8'h50, 8'h60, 1'b1, acc);
        check("t5_acc_c_on_release", 32'(acc), 32'd1);
        for (int i = 0; i < 2; i++) begin
            check("t5_no_bubble", 32'(out_valid), 32'd1);
            step(1'b0, 6'h00, 8'h00, 8'h00, 1'b1, acc);
        end
        idle(2);
        check("t5_none_lost", 32'(q.size()), 32'd0);

        // Reset with S1 and S2 both occupied
        step(1'b1, 6'b100100, 8'hF0, 8'h3C, 1'b0, acc);
        step(1'b1, 6'b100110, 8'hF0, 8'h3C, 1'b0, acc);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_outputs", 32'(obs()), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        idle(1);
        check("t6_s1_dropped", 32'(out_valid), 32'd0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
            else op = 6'($urandom);
            step(($urandom_range(0, 3) != 0), op, 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0), acc);
        end
        idle(4);
        check("rand_drained", 32'(q.size()), 32'd0);
        check("rand_idle_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
